// File: rtl/regfile_arbiter.sv
// Arbitrates one combinational-read register file between bus strobes (always win) and a held internal request.
// Latency: bus 0 cycles; internal accept t -> issue t+1 at earliest -> read data t+2.
// Backpressure: int_ready drops while a request is held; every bus strobe cycle stalls the held request.
module regfile_arbiter #(
    parameter int ADRW   = 1,
    parameter int DATW   = 1,
    parameter int STALLW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADRW-1:0]   bus_r_adr,
    input  logic [ADRW-1:0]   bus_w_adr,
    input  logic              bus_do_read,
    input  logic              bus_do_write,
    input  logic [DATW-1:0]   bus_w_data,
    output logic [DATW-1:0]   bus_rdata,
    input  logic              int_valid,
    output logic              int_ready,
    input  logic              int_we,
    input  logic [ADRW-1:0]   int_adr,
    input  logic [DATW-1:0]   int_wdata,
    output logic              int_rvalid,
    output logic [DATW-1:0]   int_rdata,
    output logic [ADRW-1:0]   mem_adr,
    output logic              mem_we,
    output logic [DATW-1:0]   mem_wdata,
    input  logic [DATW-1:0]   mem_rdata,
    output logic [STALLW-1:0] stall_cnt
);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              held_we;
    logic [ADRW-1:0]   held_adr;
    logic [DATW-1:0]   held_wdata;
    logic              bus_strobe;
    logic              issue;
    logic              capture;

    assign bus_strobe = bus_do_read | bus_do_write;
    assign bus_rdata  = mem_rdata;
    assign int_ready  = (state == EMPTY);
    assign capture    = (state == EMPTY) & int_valid;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        mem_adr   = held_adr;
        mem_we    = 1'b0;
        mem_wdata = held_wdata;
        if (bus_do_write) begin
            mem_adr   = bus_w_adr;
            mem_we    = 1'b1;
            mem_wdata = bus_w_data;
        end else if (bus_do_read) begin
            mem_adr = bus_r_adr;
        end else if (state == HELD) begin
            issue  = 1'b1;
            mem_we = held_we;
        end
        if (capture) begin
            state_nxt = HELD;
        end else if (issue) begin
            state_nxt = EMPTY;
        end
        // Reset overrides everything, including a write strobe arriving mid-reset.
        if (rst) begin
            mem_we = 1'b0;
            issue  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            held_we    <= 1'b0;
            held_adr   <= '0;
            held_wdata <= '0;
            int_rvalid <= 1'b0;
            int_rdata  <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            int_rvalid <= issue & ~held_we;
            if (capture) begin
                held_we    <= int_we;
                held_adr   <= int_adr;
                held_wdata <= int_wdata;
            end
            if (issue && !held_we) begin
                int_rdata <= mem_rdata;
            end
            if ((state == HELD) && bus_strobe && (stall_cnt != {STALLW{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: bus-path vector table, hand-written corner sequences, then random traffic vs a queue model.
module tb_regfile_arbiter;

    localparam int ADRW   = 4;
    localparam int DATW   = 8;
    localparam int STALLW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADRW-1:0]   bus_r_adr, bus_w_adr;
    logic              bus_do_read, bus_do_write;
    logic [DATW-1:0]   bus_w_data, bus_rdata;
    logic              int_valid, int_ready, int_we;
    logic [ADRW-1:0]   int_adr;
    logic [DATW-1:0]   int_wdata;
    logic              int_rvalid;
    logic [DATW-1:0]   int_rdata;
    logic [ADRW-1:0]   mem_adr;
    logic              mem_we;
    logic [DATW-1:0]   mem_wdata, mem_rdata;
    logic [STALLW-1:0] stall_cnt;

    logic [DATW-1:0] mem [16];
    logic [DATW-1:0] ref_mem [16];

    int total = 0;
    int bad   = 0;

    regfile_arbiter #(.ADRW(ADRW), .DATW(DATW), .STALLW(STALLW)) dut (
        .clk(clk), .rst(rst),
        .bus_r_adr(bus_r_adr), .bus_w_adr(bus_w_adr),
        .bus_do_read(bus_do_read), .bus_do_write(bus_do_write),
        .bus_w_data(bus_w_data), .bus_rdata(bus_rdata),
        .int_valid(int_valid), .int_ready(int_ready), .int_we(int_we),
        .int_adr(int_adr), .int_wdata(int_wdata),
        .int_rvalid(int_rvalid), .int_rdata(int_rdata),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Register file the arbiter drives: combinational read, write on clock edge.
    assign mem_rdata = mem[mem_adr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_do_read = 0; bus_do_write = 0; bus_r_adr = 0; bus_w_adr = 0; bus_w_data = 0;
        int_valid = 0; int_we = 0; int_adr = 0; int_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic int_req(input logic we, input logic [3:0] adr, input logic [7:0] d);
        int_valid = 1; int_we = we; int_adr = adr; int_wdata = d;
    endtask

    typedef struct {
        logic       rd, wr;
        logic [3:0] radr, wadr;
        logic [7:0] wdata;
        logic [3:0] e_adr;
        logic       e_we;
    } vec_t;

    vec_t vecs [8];

    typedef struct {
        logic       we;
        logic [3:0] adr;
        logic [7:0] d;
    } req_t;

    req_t q[$];

    initial begin
        logic [7:0] ref_rdata;
        logic       ref_rvalid;
        int         ref_stall;

        rst = 1;
        idle_inputs();

        // Reset with a write strobe held high: no write may reach the file.
        bus_do_write = 1; bus_w_adr = 4'h2; bus_w_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_mem_we", {31'd0, mem_we}, 0);
            tick();
            chk("rst_int_ready", {31'd0, int_ready}, 1);
            chk("rst_int_rvalid", {31'd0, int_rvalid}, 0);
            chk("rst_int_rdata", {24'd0, int_rdata}, 0);
            chk("rst_stall", {30'd0, stall_cnt}, 0);
        end
        rst = 0;
        idle_inputs();

        // Preload through the bus write path.
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = (i == 5) ? 8'hA5 : (i == 3) ? 8'h3C : 8'(i * 16 + i);
            bus_do_write = 1; bus_w_adr = 4'(i); bus_w_data = ref_mem[i];
            tick();
        end
        idle_inputs();
        do_reset();

        vecs[0] = '{1, 0, 4'h5, 4'h0, 8'h00, 4'h5, 0};
        vecs[1] = '{1, 0, 4'h3, 4'h9, 8'hFF, 4'h3, 0};
        vecs[2] = '{0, 1, 4'h0, 4'h9, 8'h5A, 4'h9, 1};
        vecs[3] = '{1, 0, 4'h9, 4'h0, 8'h00, 4'h9, 0};
        vecs[4] = '{0, 1, 4'h2, 4'hE, 8'h77, 4'hE, 1};
        vecs[5] = '{0, 0, 4'h4, 4'h4, 8'h00, 4'h0, 0};
        vecs[6] = '{1, 1, 4'h1, 4'hC, 8'h99, 4'hC, 1};
        vecs[7] = '{1, 0, 4'hC, 4'h0, 8'h00, 4'hC, 0};
        for (int i = 0; i < 8; i++) begin
            bus_do_read = vecs[i].rd; bus_do_write = vecs[i].wr;
            bus_r_adr = vecs[i].radr; bus_w_adr = vecs[i].wadr; bus_w_data = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_mem_adr", i), {28'd0, mem_adr}, {28'd0, vecs[i].e_adr});
            chk($sformatf("vec%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            if (vecs[i].e_we) begin
                chk($sformatf("vec%0d_mem_wdata", i), {24'd0, mem_wdata}, {24'd0, vecs[i].wdata});
                ref_mem[vecs[i].wadr] = vecs[i].wdata;
            end else if (vecs[i].rd) begin
                chk($sformatf("vec%0d_bus_rdata", i), {24'd0, bus_rdata}, {24'd0, ref_mem[vecs[i].radr]});
            end
            tick();
        end
        idle_inputs();

        // Internal read, free bus: issue t+1, data t+2 only.
        int_req(0, 4'h3, 8'h00);
        #1; chk("rd_ready_t", {31'd0, int_ready}, 1);
        tick();
        idle_inputs();
        #1;
        chk("rd_mem_adr_t1", {28'd0, mem_adr}, 3);
        chk("rd_mem_we_t1", {31'd0, mem_we}, 0);
        chk("rd_rvalid_t1", {31'd0, int_rvalid}, 0);
        chk("rd_ready_t1", {31'd0, int_ready}, 0);
        tick();
        chk("rd_rvalid_t2", {31'd0, int_rvalid}, 1);
        chk("rd_rdata_t2", {24'd0, int_rdata}, 8'h3C);
        chk("rd_ready_t2", {31'd0, int_ready}, 1);
        tick();
        chk("rd_rvalid_t3", {31'd0, int_rvalid}, 0);
        chk("rd_rdata_hold", {24'd0, int_rdata}, 8'h3C);

        // Held internal write collides with a bus write to the same address.
        do_reset();
        int_req(1, 4'h7, 8'h11);
        tick();
        idle_inputs();
        bus_do_write = 1; bus_w_adr = 4'h7; bus_w_data = 8'h22;
        #1;
        chk("ww_bus_wdata", {24'd0, mem_wdata}, 8'h22);
        chk("ww_bus_we", {31'd0, mem_we}, 1);
        chk("ww_ready_t1", {31'd0, int_ready}, 0);
        tick();
        idle_inputs();
        #1;
        chk("ww_int_adr", {28'd0, mem_adr}, 7);
        chk("ww_int_wdata", {24'd0, mem_wdata}, 8'h11);
        chk("ww_int_we", {31'd0, mem_we}, 1);
        chk("ww_ready_t2", {31'd0, int_ready}, 0);
        chk("ww_stall", {30'd0, stall_cnt}, 1);
        tick();
        chk("ww_ready_t3", {31'd0, int_ready}, 1);
        chk("ww_no_rvalid", {31'd0, int_rvalid}, 0);
        bus_do_read = 1; bus_r_adr = 4'h7;
        #1; chk("ww_mem7", {24'd0, bus_rdata}, 8'h11);
        ref_mem[7] = 8'h11;
        idle_inputs();
        tick();

        // Five back-to-back bus strobes saturate the 2-bit stall counter.
        do_reset();
        int_req(0, 4'h5, 8'h00);
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            bus_do_read = 1; bus_r_adr = 4'(i);
            #1; chk("sat_ready", {31'd0, int_ready}, 0);
            tick();
        end
        idle_inputs();
        #1;
        chk("sat_stall", {30'd0, stall_cnt}, 3);
        chk("sat_issue_adr", {28'd0, mem_adr}, 5);
        tick();
        chk("sat_rvalid", {31'd0, int_rvalid}, 1);
        chk("sat_rdata", {24'd0, int_rdata}, 8'hA5);

        // Reset lands on the issue cycle of a held read.
        do_reset();
        int_req(0, 4'h3, 8'h00);
        tick();
        idle_inputs();
        rst = 1;
        #1; chk("rsti_mem_we", {31'd0, mem_we}, 0);
        tick();
        rst = 0;
        chk("rsti_rvalid", {31'd0, int_rvalid}, 0);
        chk("rsti_ready", {31'd0, int_ready}, 1);
        #1; chk("rsti_no_issue", {31'd0, mem_we}, 0);
        tick();
        chk("rsti_rvalid2", {31'd0, int_rvalid}, 0);

        // Random traffic against a queue-based model.
        do_reset();
        q.delete();
        ref_rvalid = 0; ref_rdata = 8'h3C; ref_stall = 0;
        for (int c = 0; c < 400; c++) begin
            logic       issue, was_empty;
            logic [3:0] e_adr;
            logic       e_we;
            logic [7:0] e_wd;
            req_t       r;
            int         sel;

            chk("rnd_ready", {31'd0, int_ready}, {31'd0, q.size() == 0});
            chk("rnd_stall", {30'd0, stall_cnt}, 32'(ref_stall));
            chk("rnd_rvalid", {31'd0, int_rvalid}, {31'd0, ref_rvalid});
            if (ref_rvalid) chk("rnd_rdata", {24'd0, int_rdata}, {24'd0, ref_rdata});

            sel = $urandom_range(0, 3);
            bus_do_read  = (sel == 0);
            bus_do_write = (sel == 1);
            bus_r_adr  = 4'($urandom_range(0, 15));
            bus_w_adr  = 4'($urandom_range(0, 15));
            bus_w_data = 8'($urandom);
            int_valid  = ($urandom_range(0, 1) == 1);
            int_we     = ($urandom_range(0, 1) == 1);
            int_adr    = 4'($urandom_range(0, 15));
            int_wdata  = 8'($urandom);

            was_empty = (q.size() == 0);
            issue = 0; e_adr = 0; e_we = 0; e_wd = 0;
            r = '{0, 4'h0, 8'h00};
            if (bus_do_write) begin
                e_adr = bus_w_adr; e_we = 1; e_wd = bus_w_data;
            end else if (bus_do_read) begin
                e_adr = bus_r_adr;
            end else if (!was_empty) begin
                r = q.pop_front();
                issue = 1; e_adr = r.adr; e_we = r.we; e_wd = r.d;
            end
            #1;
            if (bus_do_write || bus_do_read || issue) begin
                chk("rnd_mem_adr", {28'd0, mem_adr}, {28'd0, e_adr});
                chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, e_we});
                if (e_we) chk("rnd_mem_wdata", {24'd0, mem_wdata}, {24'd0, e_wd});
            end else begin
                chk("rnd_idle_we", {31'd0, mem_we}, 0);
            end
            if (bus_do_read) chk("rnd_bus_rdata", {24'd0, bus_rdata}, {24'd0, ref_mem[bus_r_adr]});

            ref_rvalid = issue && !r.we;
            if (ref_rvalid) ref_rdata = ref_mem[r.adr];
            if (!was_empty && (bus_do_read || bus_do_write) && ref_stall < 3) ref_stall++;
            if (was_empty && int_valid) q.push_back('{int_we, int_adr, int_wdata});
            if (e_we) ref_mem[e_adr] = e_wd;
            tick();
        end
        idle_inputs();
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final_mem%0d", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
